// File: rtl/fifo_rr_scheduler.sv
// Round-robin drain of N_CH input FIFOs into one egress FIFO, with a per-channel burst limit.
// Each pop is pushed one cycle later together with its channel tag.
module fifo_rr_scheduler #(
    parameter int DATA_W    = 6,
    parameter int N_CH      = 4,
    parameter int CH_W      = 2,
    parameter int BURST_LEN = 2
)(
    input  logic                     clk,
    input  logic                     RESET,
    input  logic                     enable,
    input  logic [N_CH-1:0]          fifo_empty,
    input  logic [N_CH*DATA_W-1:0]   fifo_data,
    output logic [N_CH-1:0]          fifo_rd,
    input  logic                     out_full,
    input  logic                     out_almost_full,
    output logic                     out_wr,
    output logic [DATA_W-1:0]        out_data,
    output logic [CH_W-1:0]          out_ch,
    output logic [1:0]               state,
    output logic                     err
);
    localparam int CNT_W = $clog2(BURST_LEN + 1);

    typedef enum logic [1:0] {IDLE = 2'b00, ACTIVE = 2'b01, PAUSE = 2'b10} state_t;

    state_t                        cur, nxt;
    logic [CH_W-1:0]               last_grant, rr_pick, grant;
    logic [CNT_W-1:0]              burst_cnt, cnt_nxt;
    logic                          any_ne, stay, pop_ok;
    logic [N_CH-1:0][DATA_W-1:0]   lane_data;

    assign any_ne    = ~&fifo_empty;
    assign lane_data = fifo_data;
    assign out_data  = lane_data[out_ch];
    assign state     = cur;

    // A pop while RESET is high would be lost, since the in-flight register is cleared.
    assign pop_ok = enable & any_ne & ~out_full & ~(out_almost_full & out_wr) & ~RESET;

    // First non-empty channel after last_grant; wraps back onto last_grant itself last.
    always_comb begin
        logic [CH_W-1:0] cand;
        logic            found;
        found   = 1'b0;
        rr_pick = last_grant;
        cand    = '0;
        for (int i = 1; i <= N_CH; i++) begin
            cand = last_grant + CH_W'(i);
            if (!found && !fifo_empty[cand]) begin
                found   = 1'b1;
                rr_pick = cand;
            end
        end
    end

    // burst_cnt==0 means no burst is open, so the first grant after reset searches from ch0.
    assign stay  = (burst_cnt != '0) && (burst_cnt < CNT_W'(BURST_LEN)) && !fifo_empty[last_grant];
    assign grant = stay ? last_grant : rr_pick;

    always_comb begin
        cnt_nxt = CNT_W'(1);
        if (grant == last_grant)
            cnt_nxt = (burst_cnt == CNT_W'(BURST_LEN)) ? burst_cnt : burst_cnt + CNT_W'(1);
    end

    always_comb begin
        fifo_rd = '0;
        if (pop_ok)
            fifo_rd[grant] = 1'b1;
    end

    always_comb begin
        nxt = cur;
        case (cur)
            IDLE:    if (pop_ok) nxt = ACTIVE;
            ACTIVE:  if (!enable || !any_ne) nxt = IDLE;
                     else if (!pop_ok)      nxt = PAUSE;
            PAUSE:   if (pop_ok)                 nxt = ACTIVE;
                     else if (!enable || !any_ne) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            cur        <= IDLE;
            out_wr     <= 1'b0;
            out_ch     <= '0;
            err        <= 1'b0;
            last_grant <= CH_W'(N_CH - 1);
            burst_cnt  <= '0;
        end else begin
            cur    <= nxt;
            out_wr <= pop_ok;
            err    <= err | (out_wr & out_full);
            if (pop_ok) begin
                out_ch     <= grant;
                last_grant <= grant;
                burst_cnt  <= cnt_nxt;
            end
        end
    end
endmodule

// File: tb/tb_fifo_rr_scheduler.sv
// Directed bench for fifo_rr_scheduler: behavioural input FIFOs with 1-cycle read latency,
// push/pop logs, and hand-derived expected sequences.
module tb_fifo_rr_scheduler;
    localparam int DATA_W = 6, N_CH = 4, CH_W = 2, BURST_LEN = 2;

    logic                   clk = 1'b0, RESET = 1'b1, enable = 1'b0;
    logic                   out_full = 1'b0, out_almost_full = 1'b0;
    logic [N_CH-1:0]        fifo_empty = '1;
    logic [N_CH*DATA_W-1:0] fifo_data = '0;
    logic [N_CH-1:0]        fifo_rd;
    logic                   out_wr, err;
    logic [DATA_W-1:0]      out_data;
    logic [CH_W-1:0]        out_ch;
    logic [1:0]             state;

    fifo_rr_scheduler #(.DATA_W(DATA_W), .N_CH(N_CH), .CH_W(CH_W), .BURST_LEN(BURST_LEN)) dut (
        .clk(clk), .RESET(RESET), .enable(enable), .fifo_empty(fifo_empty),
        .fifo_data(fifo_data), .fifo_rd(fifo_rd), .out_full(out_full),
        .out_almost_full(out_almost_full), .out_wr(out_wr), .out_data(out_data),
        .out_ch(out_ch), .state(state), .err(err)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {int cyc; int ch; int data;} ev_t;
    ev_t pops[$], pushes[$];
    logic [DATA_W-1:0] q[N_CH][$];
    int cyc = 0;

    // Input FIFO bank: pop sampled at the edge, data and empty flag update just after it.
    always @(posedge clk) begin
        logic [N_CH-1:0] rd;
        rd = fifo_rd;
        if (rd != '0) begin
            chk("rd_onehot", $countones(rd), 1);
            for (int i = 0; i < N_CH; i++)
                if (rd[i]) begin
                    chk("rd_nonempty", q[i].size() != 0, 1);
                    pops.push_back('{cyc, i, 0});
                end
        end
        cyc++;
        #1;
        for (int i = 0; i < N_CH; i++) begin
            if (rd[i] && q[i].size() > 0)
                fifo_data[i*DATA_W +: DATA_W] = q[i].pop_front();
            fifo_empty[i] = (q[i].size() == 0);
        end
    end

    always @(negedge clk)
        if (out_wr) pushes.push_back('{cyc, int'(out_ch), int'(out_data)});

    task automatic load(input int ch, input int n, input int base);
        for (int j = 0; j < n; j++) q[ch].push_back(DATA_W'(base + j));
        fifo_empty[ch] = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        RESET = 1'b1; enable = 1'b0; out_full = 1'b0; out_almost_full = 1'b0;
        for (int i = 0; i < N_CH; i++) q[i].delete();
        fifo_empty = '1;
        @(negedge clk);
        RESET = 1'b0;
        pops.delete();
        pushes.delete();
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while (!(state == 2'b00 && !out_wr) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", n < budget, 1);
    endtask

    task automatic chk_push(input string tag, input int k, input int ech, input int edata);
        if (k < pushes.size()) begin
            chk($sformatf("%s_ch%0d", tag, k), pushes[k].ch, ech);
            chk($sformatf("%s_data%0d", tag, k), pushes[k].data, edata);
        end
    endtask

    initial begin
        int ord[16] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0, 1, 1, 2, 2, 3, 3};
        int seen[N_CH];

        // Reset values
        do_reset();
        chk("rst_state", state, 0);
        chk("rst_rd", fifo_rd, 0);
        chk("rst_wr", out_wr, 0);
        chk("rst_ch", out_ch, 0);
        chk("rst_err", err, 0);

        // 1: ch0 holds A,B,C; back-to-back pops, each pushed one cycle later
        load(0, 3, 1);
        enable = 1'b1;
        wait_idle(20);
        chk("t1_npush", pushes.size(), 3);
        chk("t1_npop", pops.size(), 3);
        for (int k = 0; k < 3; k++) chk_push("t1", k, 0, k + 1);
        if (pushes.size() == 3 && pops.size() == 3)
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("t1_lat%0d", k), pushes[k].cyc, pops[k].cyc + 1);
                chk($sformatf("t1_b2b%0d", k), pops[k].cyc, pops[0].cyc + k);
            end

        // 2: all channels hold 4 words; bursts of two, rotating
        do_reset();
        for (int c = 0; c < N_CH; c++) load(c, 4, c * 16);
        enable = 1'b1;
        wait_idle(60);
        chk("t2_npush", pushes.size(), 16);
        for (int c = 0; c < N_CH; c++) seen[c] = 0;
        for (int k = 0; k < 16; k++) begin
            chk_push("t2", k, ord[k], ord[k] * 16 + seen[ord[k]]);
            seen[ord[k]]++;
        end

        // 3: one free slot with a word in flight blocks the pop
        do_reset();
        load(1, 3, 16);
        enable = 1'b1;
        @(negedge clk);
        chk("t3_inflight", out_wr, 1);
        out_almost_full = 1'b1;
        #1 chk("t3_rd_blocked", fifo_rd, 0);
        @(negedge clk);
        chk("t3_pause", state, 2);
        chk("t3_wr_idle", out_wr, 0);
        out_almost_full = 1'b0;
        @(negedge clk);
        chk("t3_active", state, 1);
        wait_idle(20);
        chk("t3_npush", pushes.size(), 3);
        for (int k = 0; k < 3; k++) chk_push("t3", k, 1, 16 + k);
        chk("t3_err", err, 0);

        // 4: egress full for 5 cycles after the in-flight push lands
        do_reset();
        load(0, 4, 0);
        load(2, 2, 32);
        enable = 1'b1;
        @(negedge clk);
        out_almost_full = 1'b1;
        #1 chk("t4_rd_af", fifo_rd, 0);
        @(negedge clk);
        out_almost_full = 1'b0;
        out_full = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("t4_rd_full", fifo_rd, 0);
            chk("t4_wr_full", out_wr, 0);
            chk("t4_pause", state, 2);
            @(negedge clk);
        end
        out_full = 1'b0;
        wait_idle(30);
        chk("t4_npush", pushes.size(), 6);
        chk_push("t4", 0, 0, 0);
        chk_push("t4", 1, 0, 1);
        chk_push("t4", 2, 2, 32);
        chk_push("t4", 3, 2, 33);
        chk_push("t4", 4, 0, 2);
        chk_push("t4", 5, 0, 3);
        chk("t4_err", err, 0);

        // 5: enable drops right after a pop; the pending push still completes
        do_reset();
        load(3, 3, 48);
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        #1 chk("t5_rd_off", fifo_rd, 0);
        @(negedge clk);
        chk("t5_idle", state, 0);
        chk("t5_wr_done", out_wr, 0);
        repeat (3) @(negedge clk);
        chk("t5_npop", pops.size(), 1);
        chk("t5_npush", pushes.size(), 1);
        chk_push("t5", 0, 3, 48);

        // err is sticky once a push lands on a full egress
        do_reset();
        load(0, 1, 5);
        enable = 1'b1;
        @(negedge clk);
        out_full = 1'b1;
        chk("t7_err_pre", err, 0);
        @(negedge clk);
        chk("t7_err_set", err, 1);
        out_full = 1'b0;
        repeat (2) @(negedge clk);
        chk("t7_err_sticky", err, 1);

        // 6: reset mid-burst on ch2; the next grant searches from ch0
        pops.delete();
        pushes.delete();
        load(2, 4, 32);
        enable = 1'b1;
        @(negedge clk);
        chk("t6_npop", pops.size(), 1);
        if (pops.size() > 0) chk("t6_first_ch", pops[0].ch, 2);
        RESET = 1'b1;
        enable = 1'b0;
        @(negedge clk);
        chk("t6_state", state, 0);
        chk("t6_wr", out_wr, 0);
        chk("t6_ch", out_ch, 0);
        chk("t6_err", err, 0);
        chk("t6_rd", fifo_rd, 0);
        load(0, 1, 7);
        pops.delete();
        RESET = 1'b0;
        enable = 1'b1;
        @(negedge clk);
        chk("t6_npop_after", pops.size(), 1);
        if (pops.size() > 0) chk("t6_grant_after", pops[0].ch, 0);
        wait_idle(30);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000");
        $fatal(1, "watchdog");
    end
endmodule
